// File: rtl/fpu_addsub_pipe_if.sv
// Issue/writeback bundle for the pipelined FP add/sub unit.
// Carries the operand offer, the result, and both valid/ready pairs.
interface fpu_addsub_pipe_if #(
    parameter int EXP_WIDTH = 5,
    parameter int SIG_WIDTH = 10,
    parameter int TAG_WIDTH = 4,
    parameter int BIT_WIDTH = 1 + EXP_WIDTH + SIG_WIDTH
);
    logic                 inValid;
    logic                 inReady;
    logic                 sub;
    logic [BIT_WIDTH-1:0] fpuIn1;
    logic [BIT_WIDTH-1:0] fpuIn2;
    logic [TAG_WIDTH-1:0] inTag;
    logic                 outValid;
    logic                 outReady;
    logic [BIT_WIDTH-1:0] fpuOut;
    logic [3:0]           condCodes;
    logic [TAG_WIDTH-1:0] outTag;

    modport master (
        output inValid, sub, fpuIn1, fpuIn2, inTag, outReady,
        input  inReady, outValid, fpuOut, condCodes, outTag
    );

    modport slave (
        input  inValid, sub, fpuIn1, fpuIn2, inTag, outReady,
        output inReady, outValid, fpuOut, condCodes, outTag
    );
endinterface

// File: rtl/fpu_addsub_pipe.sv
// Three-stage pipelined floating-point adder/subtractor.
// Align, add, then normalise with round-to-nearest-even.
module fpu_addsub_pipe #(
    parameter int EXP_WIDTH = 5,
    parameter int SIG_WIDTH = 10,
    parameter int TAG_WIDTH = 4
) (
    input logic clock,
    input logic reset_L,
    fpu_addsub_pipe_if.slave bus
);
    localparam int BIT_WIDTH = 1 + EXP_WIDTH + SIG_WIDTH;
    localparam int E = EXP_WIDTH;
    localparam int M = SIG_WIDTH;
    localparam int W = M + 4;
    localparam int LZW = $clog2(W + 1);
    localparam int XW = ((E > LZW) ? E : LZW) + 2;
    localparam logic [E-1:0] EXP_ONES = '1;
    localparam logic [BIT_WIDTH-1:0] QNAN =
        {1'b0, EXP_ONES, 1'b1, {(M-1){1'b0}}};

    typedef struct packed {
        logic                 valid;
        logic [TAG_WIDTH-1:0] tag;
        logic                 special;
        logic [BIT_WIDTH-1:0] specRes;
        logic                 sign;
        logic                 effSub;
        logic [E-1:0]         exp;
        logic [W-1:0]         manL;
        logic [W-1:0]         manS;
    } alignBundle_t;

    typedef struct packed {
        logic                 valid;
        logic [TAG_WIDTH-1:0] tag;
        logic                 special;
        logic [BIT_WIDTH-1:0] specRes;
        logic                 sign;
        logic                 carry;
        logic [E-1:0]         exp;
        logic [W:0]           sum;
    } addBundle_t;

    alignBundle_t alignNext, alignQ;
    addBundle_t   addNext, addQ;

    logic                 advance;
    logic                 outValidQ;
    logic [BIT_WIDTH-1:0] fpuOutQ;
    logic [3:0]           ccQ;
    logic [TAG_WIDTH-1:0] outTagQ;

    assign advance       = !outValidQ || bus.outReady;
    assign bus.inReady   = advance;
    assign bus.outValid  = outValidQ;
    assign bus.fpuOut    = fpuOutQ;
    assign bus.condCodes = ccQ;
    assign bus.outTag    = outTagQ;

    logic         sA, sB;
    logic [E-1:0] eA, eB;
    logic [M-1:0] fA, fB;
    logic         zeroA, zeroB, infA, infB, nanA, nanB;
    logic [E+M-1:0] magA, magB;

    assign sA    = bus.fpuIn1[BIT_WIDTH-1];
    assign sB    = bus.fpuIn2[BIT_WIDTH-1] ^ bus.sub;
    assign eA    = bus.fpuIn1[M +: E];
    assign eB    = bus.fpuIn2[M +: E];
    assign fA    = bus.fpuIn1[M-1:0];
    assign fB    = bus.fpuIn2[M-1:0];
    assign zeroA = (eA == '0);
    assign zeroB = (eB == '0);
    assign infA  = (eA == EXP_ONES) && (fA == '0);
    assign infB  = (eB == EXP_ONES) && (fB == '0);
    assign nanA  = (eA == EXP_ONES) && (fA != '0);
    assign nanB  = (eB == EXP_ONES) && (fB != '0);
    assign magA  = zeroA ? '0 : {eA, fA};
    assign magB  = zeroB ? '0 : {eB, fB};

    logic           swap, sL, sS, zS;
    logic [E-1:0]   eL, eS, expDiff;
    logic [M-1:0]   fL, fS;
    logic [W-1:0]   extS;
    logic [2*W-1:0] wide;

    // Stage 1: order by magnitude, align the smaller operand, flag specials.
    always_comb begin
        swap    = magB > magA;
        sL      = swap ? sB : sA;
        sS      = swap ? sA : sB;
        eL      = swap ? eB : eA;
        eS      = swap ? eA : eB;
        fL      = swap ? fB : fA;
        fS      = swap ? fA : fB;
        zS      = swap ? zeroA : zeroB;
        expDiff = eL - eS;
        extS    = zS ? '0 : {1'b1, fS, 3'b000};
        wide    = {extS, {W{1'b0}}} >> expDiff;

        alignNext         = '0;
        alignNext.valid   = bus.inValid;
        alignNext.tag     = bus.inTag;
        alignNext.sign    = sL;
        alignNext.effSub  = sL ^ sS;
        alignNext.exp     = eL;
        alignNext.manL    = {1'b1, fL, 3'b000};
        alignNext.manS    = {wide[2*W-1:W+1], wide[W] | (|wide[W-1:0])};
        if (32'(expDiff) >= W)
            alignNext.manS = {{(W-1){1'b0}}, |extS};

        alignNext.special = 1'b1;
        if (nanA || nanB || (infA && infB && (sA != sB)))
            alignNext.specRes = QNAN;
        else if (infA)
            alignNext.specRes = {sA, EXP_ONES, {M{1'b0}}};
        else if (infB)
            alignNext.specRes = {sB, EXP_ONES, {M{1'b0}}};
        else if (zeroA && zeroB)
            alignNext.specRes = {sA & sB, {(E+M){1'b0}}};
        else if (zeroB)
            alignNext.specRes = {sA, eA, fA};
        else if (zeroA)
            alignNext.specRes = {sB, eB, fB};
        else
            alignNext.special = 1'b0;
    end

    logic [W:0] sumExt;

    // Stage 2: magnitude add or large-minus-small subtract.
    always_comb begin
        sumExt = alignQ.effSub ?
            {1'b0, alignQ.manL} - {1'b0, alignQ.manS} :
            {1'b0, alignQ.manL} + {1'b0, alignQ.manS};
        addNext         = '0;
        addNext.valid   = alignQ.valid;
        addNext.tag     = alignQ.tag;
        addNext.special = alignQ.special;
        addNext.specRes = alignQ.specRes;
        addNext.exp     = alignQ.exp;
        addNext.sum     = sumExt;
        addNext.carry   = sumExt[W];
        addNext.sign    = (sumExt == '0) ? 1'b0 : alignQ.sign;
    end

    logic [LZW-1:0]       lz;
    logic [W-1:0]         norm;
    logic [XW-1:0]        expN, expF;
    logic [M:0]           manPre, manFin;
    logic [M+1:0]         manRnd;
    logic                 roundUp, zeroRes, ovf;
    logic [BIT_WIDTH-1:0] resNext;
    logic [3:0]           ccNext;

    // Stage 3: normalise, round to nearest even, detect flush and overflow.
    always_comb begin
        lz = LZW'(W);
        for (int i = 0; i < W; i++)
            if (addQ.sum[i]) lz = LZW'(W - 1 - i);

        if (addQ.sum[W]) begin
            norm = {addQ.sum[W:2], addQ.sum[1] | addQ.sum[0]};
            expN = XW'(addQ.exp) + XW'(1);
        end else begin
            norm = addQ.sum[W-1:0] << lz;
            expN = XW'(addQ.exp) - XW'(lz);
        end

        manPre  = norm[W-1:3];
        roundUp = norm[2] & (norm[1] | norm[0] | manPre[0]);
        manRnd  = {1'b0, manPre} + {{(M+1){1'b0}}, roundUp};
        if (manRnd[M+1]) begin
            manFin = manRnd[M+1:1];
            expF   = expN + XW'(1);
        end else begin
            manFin = manRnd[M:0];
            expF   = expN;
        end

        zeroRes = (addQ.sum == '0) || expN[XW-1] || (expN == '0);
        ovf     = !zeroRes && (expF >= XW'(EXP_ONES));

        resNext = {addQ.sign, expF[E-1:0], manFin[M-1:0]};
        ccNext  = {1'b0, addQ.carry, addQ.sign, 1'b0};
        if (addQ.special) begin
            resNext = addQ.specRes;
            ccNext  = {addQ.specRes[BIT_WIDTH-2:0] == '0, 1'b0,
                       addQ.specRes[BIT_WIDTH-1], 1'b0};
        end else if (zeroRes) begin
            resNext   = {addQ.sign, {(E+M){1'b0}}};
            ccNext[3] = 1'b1;
        end else if (ovf) begin
            resNext   = {addQ.sign, EXP_ONES, {M{1'b0}}};
            ccNext[0] = 1'b1;
        end
    end

    // Stage registers: all advance together or hold together.
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            alignQ <= '0;
            addQ   <= '0;
        end else if (advance) begin
            alignQ <= alignNext;
            addQ   <= addNext;
        end
    end

    // Output register: visible result, flags and tag.
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            outValidQ <= 1'b0;
            fpuOutQ   <= '0;
            ccQ       <= '0;
            outTagQ   <= '0;
        end else if (advance) begin
            outValidQ <= addQ.valid;
            if (addQ.valid) begin
                fpuOutQ <= resNext;
                ccQ     <= ccNext;
                outTagQ <= addQ.tag;
            end
        end
    end
endmodule

// File: tb/tb_fpu_addsub_pipe.sv
// Scoreboard bench for fpu_addsub_pipe (half precision).
// Directed vectors, backpressure hold and asynchronous reset flush.
module tb_fpu_addsub_pipe;
    logic clock = 1'b0;
    logic reset_L;
    int   testsRun = 0;
    int   testsFailed = 0;
    int   cycleCnt = 0;
    int   outCount = 0;

    fpu_addsub_pipe_if #(.EXP_WIDTH(5), .SIG_WIDTH(10), .TAG_WIDTH(4)) bus ();

    fpu_addsub_pipe #(.EXP_WIDTH(5), .SIG_WIDTH(10), .TAG_WIDTH(4)) dut (
        .clock(clock),
        .reset_L(reset_L),
        .bus(bus)
    );

    always #5 clock = ~clock;

    // Cycle counter used for latency measurement.
    always @(posedge clock) cycleCnt <= cycleCnt + 1;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        s;
        logic [15:0] r;
        logic [3:0]  cc;
    } vec_t;

    typedef struct {
        logic [15:0] res;
        logic [3:0]  cc;
        logic [3:0]  tag;
        int          cyc;
        bit          chkLat;
    } exp_t;

    localparam int NV = 21;
    vec_t        vecs [NV];
    exp_t        expQ [$];
    exp_t        cur;
    logic [15:0] drvRes;
    logic [3:0]  drvCc;
    bit          latOn;

    task automatic checkVal(input string tag, input logic [31:0] got,
                            input logic [31:0] want);
        testsRun++;
        if (got !== want) begin
            testsFailed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    // Scoreboard: push on accept, pop and compare on result transfer.
    always @(negedge clock) begin
        if (reset_L) begin
            if (bus.inValid && bus.inReady)
                expQ.push_back('{res: drvRes, cc: drvCc, tag: bus.inTag,
                                 cyc: cycleCnt, chkLat: latOn});
            if (bus.outValid && bus.outReady) begin
                if (expQ.size() == 0) begin
                    checkVal("spurious", 32'(bus.outValid), 0);
                end else begin
                    cur = expQ.pop_front();
                    checkVal("result", 32'(bus.fpuOut), 32'(cur.res));
                    checkVal("ccodes", 32'(bus.condCodes), 32'(cur.cc));
                    checkVal("tag", 32'(bus.outTag), 32'(cur.tag));
                    if (cur.chkLat)
                        checkVal("latency", 32'(cycleCnt - cur.cyc), 3);
                    outCount++;
                end
            end
        end
    end

    task automatic sendOp(input vec_t v, input logic [3:0] tag);
        bit acc;
        int waitCyc;
        acc = 1'b0;
        waitCyc = 0;
        bus.inValid = 1'b1;
        bus.fpuIn1  = v.a;
        bus.fpuIn2  = v.b;
        bus.sub     = v.s;
        bus.inTag   = tag;
        drvRes      = v.r;
        drvCc       = v.cc;
        while (!acc && waitCyc < 50) begin
            @(negedge clock);
            acc = bus.inReady;
            @(posedge clock);
            #1;
            waitCyc++;
        end
        checkVal("accept", 32'(acc), 1);
        bus.inValid = 1'b0;
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while (expQ.size() != 0 && n < 200) begin
            @(posedge clock);
            n++;
        end
        checkVal("drained", 32'(expQ.size()), 0);
        @(posedge clock);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{16'h3C00, 16'h4000, 1'b0, 16'h4200, 4'b0000};
        vecs[1]  = '{16'h3C00, 16'h3C00, 1'b1, 16'h0000, 4'b1000};
        vecs[2]  = '{16'h3C00, 16'h1000, 1'b0, 16'h3C00, 4'b0000};
        vecs[3]  = '{16'h3C01, 16'h1000, 1'b0, 16'h3C02, 4'b0000};
        vecs[4]  = '{16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00, 4'b0101};
        vecs[5]  = '{16'h7C00, 16'h7C00, 1'b1, 16'h7E00, 4'b0000};
        vecs[6]  = '{16'h4000, 16'h3C00, 1'b1, 16'h3C00, 4'b0000};
        vecs[7]  = '{16'h3C00, 16'h4000, 1'b1, 16'hBC00, 4'b0010};
        vecs[8]  = '{16'h3C00, 16'h0000, 1'b0, 16'h3C00, 4'b0000};
        vecs[9]  = '{16'h0000, 16'h3C00, 1'b1, 16'hBC00, 4'b0010};
        vecs[10] = '{16'h8000, 16'h8000, 1'b0, 16'h8000, 4'b1010};
        vecs[11] = '{16'h0000, 16'h0000, 1'b1, 16'h0000, 4'b1000};
        vecs[12] = '{16'h7E00, 16'h3C00, 1'b0, 16'h7E00, 4'b0000};
        vecs[13] = '{16'h7C00, 16'h3C00, 1'b0, 16'h7C00, 4'b0000};
        vecs[14] = '{16'h3C00, 16'h7C00, 1'b1, 16'hFC00, 4'b0010};
        vecs[15] = '{16'h0401, 16'h0400, 1'b1, 16'h0000, 4'b1000};
        vecs[16] = '{16'h4400, 16'h3C00, 1'b0, 16'h4500, 4'b0000};
        vecs[17] = '{16'hC000, 16'h3C00, 1'b0, 16'hBC00, 4'b0010};
        vecs[18] = '{16'h3C01, 16'h0400, 1'b1, 16'h3C01, 4'b0000};
        vecs[19] = '{16'h7BFF, 16'h4C00, 1'b0, 16'h7C00, 4'b0001};
        vecs[20] = '{16'h7BFF, 16'h5000, 1'b0, 16'h7C00, 4'b0101};

        reset_L      = 1'b0;
        bus.inValid  = 1'b0;
        bus.sub      = 1'b0;
        bus.fpuIn1   = '0;
        bus.fpuIn2   = '0;
        bus.inTag    = '0;
        bus.outReady = 1'b1;
        drvRes       = '0;
        drvCc        = '0;
        latOn        = 1'b1;

        repeat (2) @(posedge clock);
        #1;
        checkVal("rstOutValid", 32'(bus.outValid), 0);
        checkVal("rstFpuOut", 32'(bus.fpuOut), 0);
        checkVal("rstCond", 32'(bus.condCodes), 0);
        checkVal("rstTag", 32'(bus.outTag), 0);
        #2 reset_L = 1'b1;
        @(negedge clock);
        checkVal("rstInReady", 32'(bus.inReady), 1);
        @(posedge clock);
        #1;

        // Back-to-back directed vectors, no stalls.
        outCount = 0;
        for (int i = 0; i < NV; i++) sendOp(vecs[i], 4'(i));
        waitDrain();
        checkVal("directedCount", 32'(outCount), NV);

        // Six-op stream with a four-cycle consumer stall.
        outCount = 0;
        latOn = 1'b0;
        fork
            begin
                for (int i = 0; i < 6; i++) sendOp(vecs[i], 4'(i));
            end
            begin
                repeat (4) @(posedge clock);
                #1;
                bus.outReady = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    @(negedge clock);
                    checkVal("holdValid", 32'(bus.outValid), 1);
                    checkVal("holdRes", 32'(bus.fpuOut), 32'(vecs[1].r));
                    checkVal("holdCc", 32'(bus.condCodes), 32'(vecs[1].cc));
                    checkVal("holdTag", 32'(bus.outTag), 1);
                    checkVal("holdInReady", 32'(bus.inReady), 0);
                end
                @(posedge clock);
                #1;
                bus.outReady = 1'b1;
            end
        join
        waitDrain();
        checkVal("bpCount", 32'(outCount), 6);

        // Asynchronous reset with three operations in flight.
        outCount = 0;
        for (int i = 0; i < 3; i++) sendOp(vecs[16 + i], 4'(8 + i));
        checkVal("preRstValid", 32'(bus.outValid), 1);
        #2 reset_L = 1'b0;
        #1;
        checkVal("rstDropValid", 32'(bus.outValid), 0);
        expQ.delete();
        @(posedge clock);
        #3 reset_L = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            checkVal("noStale", 32'(bus.outValid), 0);
        end
        @(posedge clock);
        #1;
        latOn = 1'b1;
        sendOp(vecs[0], 4'hA);
        waitDrain();
        checkVal("postRstCount", 32'(outCount), 1);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule

// File: doc/fpu_addsub_pipe.md
Name: fpu_addsub_pipe

Overview:
- Pipelined, parametrised IEEE-754 style floating-point adder/subtractor. Successor to the combinational add/sub datapath.
- Accepts packed operands and unpacks them internally. Adds guard/round/sticky bits and round-to-nearest-even. Handles zero, infinity and NaN.
- Three-stage valid/ready pipeline with backpressure and a pass-through tag. Sits between the FPU issue logic and writeback.

Parameters:
- EXP_WIDTH, 5, exponent field width (bias = 2^(EXP_WIDTH-1)-1).
- SIG_WIDTH, 10, stored fraction width (hidden bit implicit).
- BIT_WIDTH, 1+EXP_WIDTH+SIG_WIDTH, packed operand width (derived; must not be overridden inconsistently).
- TAG_WIDTH, 4, opaque tag carried alongside each operation.

Ports:
- clock  in  1  single clock, rising edge.
- reset_L  in  1  asynchronous, active-low reset.
- inValid  in  1  operation offered.
- inReady  out  1  pipeline can accept this cycle.
- sub  in  1  1 = In1 - In2, 0 = In1 + In2.
- fpuIn1, fpuIn2  in  BIT_WIDTH  packed operands {sign, exp, frac}.
- inTag  in  TAG_WIDTH  returned with the result.
- outValid  out  1  result present.
- outReady  in  1  consumer accepts result.
- fpuOut  out  BIT_WIDTH  packed result.
- condCodes  out  4  {Z, C, N, V}.
- outTag  out  TAG_WIDTH  tag of this result.

Behaviour:
- Reset (asynchronous, reset_L=0):
  - All stage valid bits cleared.
  - outValid=0, fpuOut=0, condCodes=0, outTag=0.
  - inReady=1 once reset is released.
  - Reset mid-operation discards all in-flight operations; no result emerges after reset.
- Handshake:
  - advance = !outValid || outReady.
  - inReady = advance.
  - An input transfers when inValid && inReady.
  - When advance=0, all stages hold: contents, valids and outputs stay stable.
  - Bubbles propagate as valid=0.
  - Latency is exactly 3 cycles from accept to outValid when there are no stalls. Throughput is 1 per cycle.
  - A result is consumed when outValid && outReady; a new result may be presented in the same cycle.
- Stage 1 (unpack/align):
  - effS2 = S2 ^ sub.
  - Exp = 0 is treated as zero: subnormals are flushed to zero on input and output.
  - Prepend the hidden 1. The operand with the larger exponent is kept; the tie-break is a larger significand.
  - Right-shift the other significand by the exponent difference into a SIG_WIDTH+4 field {1, frac, G, R, S}.
  - Shifted-out bits are ORed into S. Shifts of SIG_WIDTH+3 or more leave only the sticky bit.
  - Special-case flags are computed here and carried forward.
- Stage 2 (add):
  - Equal effective signs: magnitude add. Otherwise: large minus small.
  - The result is never negative because of the ordering.
  - Result sign = sign of the larger-magnitude operand.
  - Exact-zero difference gives +0.
  - C = carry out of the significand add.
- Stage 3 (normalise/round):
  - On carry: shift right 1 (sticky preserved) and exp+1.
  - Otherwise: shift left by leading-zero count and decrement exp.
  - If exp would go ≤ 0, flush to ±0 (sign kept).
  - Round to nearest, ties to even, using G/R/S.
  - A rounding carry renormalises and increments exp.
  - Exp reaching all-ones gives ±inf with V=1.
- Special cases (override the arithmetic):
  - Either input NaN, or inf - inf (effective): canonical quiet NaN = {0, all-ones exp, 1 followed by zeros}.
  - Single inf: that inf, with the effective sign for operand 2.
  - x ± 0: x, with the effective sign for operand 2. For 0 + 0 the sign is the AND of both effective signs.
- Condition codes:
  - Z = result is ±0.
  - C as above (0 for special cases).
  - N = result sign bit (0 for NaN).
  - V = overflow to inf from finite operands only.

Test Plan:
- Single-cycle add, no stall: 0x3C00 + 0x4000, sub=0, tag=5 -> 3 cycles later fpuOut=0x4200, outTag=5, condCodes=0000.
- Cancellation: 0x3C00 - 0x3C00 -> 0x0000, Z=1, N=0.
- Round-to-nearest-even:
  - 0x3C00 + 0x1000 -> 0x3C00 (tie, even).
  - 0x3C01 + 0x1000 -> 0x3C02 (tie, odd rounds up).
- Overflow: 0x7BFF + 0x7BFF -> 0x7C00, V=1, C=1. Special: 0x7C00 - 0x7C00 -> 0x7E00, V=0.
- Backpressure: stream 6 back-to-back ops with tags 0..5, and hold outReady=0 for 4 cycles mid-stream.
  - Outputs stay stable while held.
  - inReady=0 while held.
  - All 6 results emerge in order, with none lost or duplicated.
- Asynchronous reset: assert reset_L=0 between clock edges with 3 ops in flight -> outValid drops immediately; after release no stale results emerge and the next op completes in 3 cycles.
